// File: rtl/riscv_dbus_arbiter.sv
// Two-master arbiter for the riscv_io_bridge data port, one transaction in flight.
// Optional round-robin arbitration is enabled with `define DBUS_ARB_RR_EN.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_WRITE_SB
`define CACHE_D_WRITE_SB 2'b01
`endif
`ifndef CACHE_D_WRITE_SH
`define CACHE_D_WRITE_SH 2'b10
`endif
`ifndef CACHE_D_WRITE_SW
`define CACHE_D_WRITE_SW 2'b11
`endif

module riscv_dbus_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_req,
  input  logic                          m0_we,
  input  logic [`CACHE_D_WRITE_LEN-1:0] m0_wtype,
  input  logic [31:0]                   m0_addr,
  input  logic [31:0]                   m0_wdata,
  output logic                          m0_ack,
  output logic [31:0]                   m0_rdata,
  input  logic                          m1_req,
  input  logic                          m1_we,
  input  logic [`CACHE_D_WRITE_LEN-1:0] m1_wtype,
  input  logic [31:0]                   m1_addr,
  input  logic [31:0]                   m1_wdata,
  output logic                          m1_ack,
  output logic [31:0]                   m1_rdata,
  output logic                          bus_write_en,
  output logic [`CACHE_D_WRITE_LEN-1:0] bus_write,
  output logic [31:0]                   bus_addr,
  output logic [31:0]                   bus_wdata,
  input  logic [31:0]                   bus_rdata,
  output logic                          busy
);

  // Handshake: a master raises req with stable fields and holds them until its
  // ack pulse; ack is a single cycle and rdata is only meaningful during it.

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                         state, state_nxt;
  logic                           owner;
  logic                           last_owner;
  logic                           grant_m1;
  logic [CW-1:0]                  lat_cnt;
  logic                           lat_done;
  logic [31:0]                    rdata_q;
  logic                           we_q;
  logic [`CACHE_D_WRITE_LEN-1:0]  wtype_q;
  logic [31:0]                    addr_q;
  logic [31:0]                    wdata_q;
  logic                           in_access;
  logic                           in_ack;
  logic                           unused_last_owner;

`ifdef DBUS_ARB_RR_EN
  // On a tie the master that did not own the previous transaction wins.
  assign grant_m1 = m1_req & (~m0_req | ~last_owner);
`else
  assign grant_m1 = m1_req & ~m0_req;
`endif
  assign unused_last_owner = last_owner;

  assign lat_done = (lat_cnt == CW'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_cnt    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      wtype_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner   <= grant_m1;
            lat_cnt <= '0;
            we_q    <= grant_m1 ? m1_we    : m0_we;
            wtype_q <= grant_m1 ? m1_wtype : m0_wtype;
            addr_q  <= grant_m1 ? m1_addr  : m0_addr;
            wdata_q <= grant_m1 ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + CW'(1);
          if (lat_done) rdata_q <= bus_rdata;
        end
        ACK: last_owner <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m0_req || m1_req) state_nxt = ACCESS;
      ACCESS:  if (lat_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks the store strobe and the ack so an aborted access leaves no trace.
  assign in_access    = (state == ACCESS);
  assign in_ack       = (state == ACK) && !rst;
  assign bus_write_en = in_access && (lat_cnt == '0) && we_q && !rst;
  assign bus_write    = in_access ? wtype_q : '0;
  assign bus_addr     = in_access ? addr_q  : '0;
  assign bus_wdata    = in_access ? wdata_q : '0;

  assign m0_ack   = in_ack && !owner;
  assign m1_ack   = in_ack && owner;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_riscv_dbus_arbiter.sv
// Directed bench for riscv_dbus_arbiter: one instance at RD_LAT=1 with a small
// bridge model (sw/led registers, fixed memory words), one at RD_LAT=3.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_WRITE_SB
`define CACHE_D_WRITE_SB 2'b01
`endif
`ifndef CACHE_D_WRITE_SH
`define CACHE_D_WRITE_SH 2'b10
`endif
`ifndef CACHE_D_WRITE_SW
`define CACHE_D_WRITE_SW 2'b11
`endif

module tb_riscv_dbus_arbiter;
  localparam int WL = `CACHE_D_WRITE_LEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [WL-1:0] m0_wtype, m1_wtype, bus_write;
  logic [31:0]   m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic          bus_write_en, busy;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata;

  logic          d3_m0_req, d3_m0_we, d3_m0_ack, d3_m1_req, d3_m1_we, d3_m1_ack;
  logic [WL-1:0] d3_m0_wtype, d3_m1_wtype, d3_bus_write;
  logic [31:0]   d3_m0_addr, d3_m0_wdata, d3_m0_rdata, d3_m1_addr, d3_m1_wdata, d3_m1_rdata;
  logic          d3_bus_write_en, d3_busy;
  logic [31:0]   d3_bus_addr, d3_bus_wdata, d3_bus_rdata;

  logic [31:0] led = 32'h0;
  int tests = 0;
  int fails = 0;
  int m0_ack_cnt = 0, m1_ack_cnt = 0, we_cnt = 0, d3_we_cnt = 0;

  riscv_dbus_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wtype(m0_wtype), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wtype(m1_wtype), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_write_en(bus_write_en), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
  );

  riscv_dbus_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_wtype(d3_m0_wtype), .m0_addr(d3_m0_addr),
    .m0_wdata(d3_m0_wdata), .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
    .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_wtype(d3_m1_wtype), .m1_addr(d3_m1_addr),
    .m1_wdata(d3_m1_wdata), .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
    .bus_write_en(d3_bus_write_en), .bus_write(d3_bus_write), .bus_addr(d3_bus_addr),
    .bus_wdata(d3_bus_wdata), .bus_rdata(d3_bus_rdata), .busy(d3_busy)
  );

  function automatic logic [31:0] bridge_rd(input logic [31:0] a, input logic [31:0] led_v);
    case (a)
      32'hFFFF_FC00: return 32'h00A5_A5A5;
      32'hFFFF_FC04: return led_v;
      32'h0000_0100: return 32'h1111_0100;
      32'h0000_0200: return 32'h2222_0200;
      32'h0000_0040: return 32'hDEAD_BEEF;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [WL-1:0] wt, input logic [1:0] a);
    logic [3:0] be;
    if (wt == `CACHE_D_WRITE_SB)      be = 4'b0001 << a;
    else if (wt == `CACHE_D_WRITE_SH) be = a[1] ? 4'b1100 : 4'b0011;
    else                              be = 4'b1111;
    merge = old;
    for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = wd[8*i +: 8];
  endfunction

  assign bus_rdata    = bridge_rd(bus_addr, led);
  assign d3_bus_rdata = bridge_rd(d3_bus_addr, 32'h0);

  always @(posedge clk)
    if (bus_write_en && ({bus_addr[31:2], 2'b00} == 32'hFFFF_FC04))
      led <= merge(led, bus_wdata, bus_write, bus_addr[1:0]);

  always @(negedge clk) begin
    if (m0_ack) m0_ack_cnt++;
    if (m1_ack) m1_ack_cnt++;
    if (bus_write_en) we_cnt++;
    if (d3_bus_write_en) d3_we_cnt++;
  end

  task automatic txn(input int m, input logic we, input logic [WL-1:0] wt, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output int lat);
    logic got;
    lat = 0; rd = '0; got = 1'b0;
    @(posedge clk); #1;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_wtype = wt; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_wtype = wt; m1_addr = a; m1_wdata = wd;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((m == 0) ? m0_ack : m1_ack) begin
        rd  = (m == 0) ? m0_rdata : m1_rdata;
        got = 1'b1;
        break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tests++;
    if (!got) begin fails++; $display("FAIL txn_ack master=%0d: no ack within 20 cycles", m); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_wtype = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_wtype = '0; m1_addr = '0; m1_wdata = '0;
    d3_m0_req = 0; d3_m0_we = 0; d3_m0_wtype = '0; d3_m0_addr = '0; d3_m0_wdata = '0;
    d3_m1_req = 0; d3_m1_we = 0; d3_m1_wtype = '0; d3_m1_addr = '0; d3_m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({m0_ack, m1_ack, busy, bus_write_en} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0000", {m0_ack, m1_ack, busy, bus_write_en});
    end
    tests++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata);
    end
    tests++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_write !== '0) begin
      fails++; $display("FAIL reset_bus got addr=%h wdata=%h write=%b exp=0", bus_addr, bus_wdata, bus_write);
    end
    tests++;
    if (d3_busy !== 1'b0 || d3_m0_ack !== 1'b0) begin
      fails++; $display("FAIL reset_d3 got busy=%b ack=%b exp=0/0", d3_busy, d3_m0_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_wtype = `CACHE_D_WRITE_SW; m0_addr = 32'hFFFF_FC00;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1 || bus_addr !== 32'hFFFF_FC00 || bus_write_en !== 1'b0 || m0_ack !== 1'b0) begin
      fails++; $display("FAIL read_access got busy=%b addr=%h we=%b ack=%b exp=1/fffffc00/0/0",
                        busy, bus_addr, bus_write_en, m0_ack);
    end
    @(posedge clk); #1;
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h00A5_A5A5) begin
      fails++; $display("FAIL read_ack got ack=%b rdata=%h exp=1/00a5a5a5", m0_ack, m0_rdata);
    end
    tests++;
    if (m1_ack !== 1'b0 || m1_rdata !== 32'h0 || bus_addr !== 32'h0) begin
      fails++; $display("FAIL read_other got m1_ack=%b m1_rdata=%h addr=%h exp=0/0/0", m1_ack, m1_rdata, bus_addr);
    end
    m0_req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (m0_ack !== 1'b0 || m0_rdata !== 32'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL read_after got ack=%b rdata=%h busy=%b exp=0/0/0", m0_ack, m0_rdata, busy);
    end
  endtask

  task automatic test_write;
    int w0, a0, a1, lat;
    logic [31:0] rd;
    w0 = we_cnt; a0 = m0_ack_cnt; a1 = m1_ack_cnt;
    txn(1, 1'b1, `CACHE_D_WRITE_SW, 32'hFFFF_FC04, 32'h1234_5678, rd, lat);
    @(posedge clk); #1;
    tests++;
    if (lat != 2) begin fails++; $display("FAIL write_latency got=%0d exp=2", lat); end
    tests++;
    if (we_cnt - w0 != 1) begin fails++; $display("FAIL write_pulses got=%0d exp=1", we_cnt - w0); end
    tests++;
    if (led !== 32'h1234_5678) begin fails++; $display("FAIL write_led got=%h exp=12345678", led); end
    tests++;
    if (m0_ack_cnt != a0 || m1_ack_cnt - a1 != 1) begin
      fails++; $display("FAIL write_acks got m0=%0d m1=%0d exp=0/1", m0_ack_cnt - a0, m1_ack_cnt - a1);
    end
  endtask

  task automatic test_arbitration;
    int exp_o[4];
    int n;
    int got;
`ifdef DBUS_ARB_RR_EN
    exp_o[0] = 0; exp_o[1] = 1; exp_o[2] = 0; exp_o[3] = 1;
`else
    exp_o[0] = 0; exp_o[1] = 0; exp_o[2] = 0; exp_o[3] = 0;
`endif
    n = 0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack) begin
        got = m1_ack ? 1 : 0;
        tests++;
        if (m0_ack && m1_ack) begin fails++; $display("FAIL arb_both_ack txn=%0d got=11 exp=one-hot", n); end
        tests++;
        if (got != exp_o[n]) begin fails++; $display("FAIL arb_order txn=%0d got=m%0d exp=m%0d", n, got, exp_o[n]); end
        tests++;
        if (got == 0 && m0_rdata !== 32'h1111_0100) begin
          fails++; $display("FAIL arb_rdata_m0 got=%h exp=11110100", m0_rdata);
        end else if (got == 1 && m1_rdata !== 32'h2222_0200) begin
          fails++; $display("FAIL arb_rdata_m1 got=%h exp=22220200", m1_rdata);
        end
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tests++;
    if (n != 4) begin fails++; $display("FAIL arb_count got=%0d exp=4", n); end
    @(posedge clk);
  endtask

  task automatic test_latency3;
    int lat, busyc, w0;
    logic got;
    logic [31:0] rd;
    lat = 0; busyc = 0; got = 1'b0; rd = '0;
    @(posedge clk); #1;
    d3_m0_req = 1'b1; d3_m0_we = 1'b0; d3_m0_addr = 32'h0000_0040;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (d3_busy) busyc++;
      if (d3_m0_ack) begin rd = d3_m0_rdata; got = 1'b1; break; end
    end
    d3_m0_req = 1'b0;
    @(posedge clk); #1;
    if (d3_busy) busyc++;
    tests++;
    if (!got || lat != 4) begin fails++; $display("FAIL lat3_latency got=%0d ack=%b exp=4/1", lat, got); end
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lat3_rdata got=%h exp=deadbeef", rd); end
    tests++;
    if (busyc != 4) begin fails++; $display("FAIL lat3_busy got=%0d exp=4", busyc); end

    w0 = d3_we_cnt; got = 1'b0;
    d3_m0_req = 1'b1; d3_m0_we = 1'b1; d3_m0_wtype = `CACHE_D_WRITE_SW; d3_m0_wdata = 32'h5555_AAAA;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (d3_m0_ack) begin got = 1'b1; break; end
    end
    d3_m0_req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (!got || d3_we_cnt - w0 != 1) begin
      fails++; $display("FAIL lat3_write_pulses got=%0d ack=%b exp=1/1", d3_we_cnt - w0, got);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] led0;
    int a1;
    led0 = led; a1 = m1_ack_cnt;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_wtype = `CACHE_D_WRITE_SW; m1_addr = 32'hFFFF_FC04; m1_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (bus_write_en !== 1'b0 || m1_ack !== 1'b0) begin
      fails++; $display("FAIL abort_mask got we=%b ack=%b exp=0/0", bus_write_en, m1_ack);
    end
    @(posedge clk); #1;
    rst = 1'b0; m1_req = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_write !== '0 || bus_write_en !== 1'b0) begin
      fails++; $display("FAIL abort_idle got busy=%b addr=%h wdata=%h write=%b we=%b exp=0",
                        busy, bus_addr, bus_wdata, bus_write, bus_write_en);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (led !== led0 || m1_ack_cnt != a1) begin
      fails++; $display("FAIL abort_effect got led=%h acks=%0d exp led=%h acks=0", led, m1_ack_cnt - a1, led0);
    end
  endtask

  task automatic test_byte_store;
    int w0, lat;
    logic [31:0] rd;
    txn(0, 1'b1, `CACHE_D_WRITE_SW, 32'hFFFF_FC04, 32'h1122_3344, rd, lat);
    @(posedge clk); #1;
    tests++;
    if (led !== 32'h1122_3344) begin fails++; $display("FAIL sb_setup_led got=%h exp=11223344", led); end
    w0 = we_cnt;
    txn(0, 1'b1, `CACHE_D_WRITE_SB, 32'hFFFF_FC05, 32'h0000_AB00, rd, lat);
    @(posedge clk); #1;
    tests++;
    if (led !== 32'h1122_AB44) begin fails++; $display("FAIL sb_led got=%h exp=1122ab44", led); end
    tests++;
    if (we_cnt - w0 != 1) begin fails++; $display("FAIL sb_pulses got=%0d exp=1", we_cnt - w0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_latency3();
    test_reset_abort();
    test_byte_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
